// File: rtl/alu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : alu_pkg                                                         |
// | Purpose  : Shared encodings for the execute stage: alu_op classes, decoded |
// |            ALU control codes, RV32M funct3 codes, MDU FSM states and a    |
// |            helper mapping the plain funct3 field to an ALU control code.   |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package alu_pkg;

   // alu_op classes coming from the main decoder
   typedef enum logic [1:0] {
      ALUOP_ADD    = 2'b00,   // loads / stores / address generation
      ALUOP_BRANCH = 2'b01,   // branch compare (subtract)
      ALUOP_RTYPE  = 2'b10,
      ALUOP_ITYPE  = 2'b11
   } alu_op_e;

   // Decoded ALU control codes
   localparam logic [3:0] CTRL_AND  = 4'b0000;
   localparam logic [3:0] CTRL_OR   = 4'b0001;
   localparam logic [3:0] CTRL_ADD  = 4'b0010;
   localparam logic [3:0] CTRL_XOR  = 4'b0011;
   localparam logic [3:0] CTRL_SLL  = 4'b0100;
   localparam logic [3:0] CTRL_SRL  = 4'b0101;
   localparam logic [3:0] CTRL_SUB  = 4'b0110;
   localparam logic [3:0] CTRL_SRA  = 4'b0111;
   localparam logic [3:0] CTRL_SLT  = 4'b1000;
   localparam logic [3:0] CTRL_SLTU = 4'b1001;
   localparam logic [3:0] CTRL_MDU  = 4'b1111;

   // funct7 patterns
   localparam logic [6:0] F7_BASE   = 7'b0000000;
   localparam logic [6:0] F7_ALT    = 7'b0100000;
   localparam logic [6:0] F7_MULDIV = 7'b0000001;

   // RV32M funct3 codes
   localparam logic [2:0] F3_MUL    = 3'b000;
   localparam logic [2:0] F3_MULH   = 3'b001;
   localparam logic [2:0] F3_MULHSU = 3'b010;
   localparam logic [2:0] F3_MULHU  = 3'b011;
   localparam logic [2:0] F3_DIV    = 3'b100;
   localparam logic [2:0] F3_DIVU   = 3'b101;
   localparam logic [2:0] F3_REM    = 3'b110;
   localparam logic [2:0] F3_REMU   = 3'b111;

   // MDU sequencer states
   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_BUSY = 2'b01,
      ST_DONE = 2'b10
   } mdu_state_e;

   // Base integer op selected by funct3 alone (funct7 variants handled by caller)
   function automatic logic [3:0] base_ctrl(input logic [2:0] f3);
      logic [3:0] c;
      case (f3)
         3'b000:  c = CTRL_ADD;
         3'b001:  c = CTRL_SLL;
         3'b010:  c = CTRL_SLT;
         3'b011:  c = CTRL_SLTU;
         3'b100:  c = CTRL_XOR;
         3'b101:  c = CTRL_SRL;
         3'b110:  c = CTRL_OR;
         default: c = CTRL_AND;
      endcase
      return c;
   endfunction

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_exec_unit_mdu_iter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mdu_iter                                                        |
// | Purpose  : Iterative RV32M multiply/divide. One shift-add (multiply) or    |
// |            restoring-subtract (divide) step per cycle over XLEN cycles on  |
// |            operand magnitudes; sign, divide-by-zero and overflow results   |
// |            are applied when the last step is taken.                        |
// | Ports    : clk, rst     clock, synchronous active-high reset              |
// |            flush        abandon any operation, return to idle             |
// |            start        accept funct3/a/b (honoured only when idle)       |
// |            funct3,a,b   operation and operands                            |
// |            busy         stepping in progress                              |
// |            done         result valid (one cycle)                          |
// |            result       registered MDU result                             |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module mdu_iter
   import alu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            start,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam int CW = $clog2(XLEN);

   mdu_state_e        r_state;
   mdu_state_e        w_state_nx;

   logic [CW-1:0]     r_cnt;
   logic [2:0]        r_f3;
   logic [XLEN-1:0]   r_a;        // original dividend, needed for the /0 remainder
   logic [XLEN-1:0]   r_ma;       // multiplicand magnitude
   logic [XLEN-1:0]   r_mb;       // divisor magnitude
   logic [XLEN-1:0]   r_hi;       // product high half / partial remainder
   logic [XLEN-1:0]   r_lo;       // product low half + multiplier / quotient
   logic              r_neg_q;    // negate product or quotient at the end
   logic              r_neg_r;    // negate remainder at the end
   logic              r_div0;
   logic              r_ovf;
   logic [XLEN-1:0]   r_result;

   logic              w_last;
   logic              w_sgn_a, w_sgn_b, w_neg_a, w_neg_b;
   logic [XLEN-1:0]   w_abs_a, w_abs_b;
   logic [XLEN:0]     w_mul_sum;
   logic [XLEN:0]     w_div_sh;
   logic [XLEN:0]     w_div_df;
   logic [XLEN-1:0]   w_hi_nx, w_lo_nx;
   logic [2*XLEN-1:0] w_prod, w_prod_s;
   logic [XLEN-1:0]   w_q_s, w_r_s;
   logic [XLEN-1:0]   w_final;

   assign w_last = (r_cnt == CW'(XLEN-1));

   // ---------------- state register / next state ----------------
   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nx;
   end

   always_comb begin
      w_state_nx = r_state;
      case (r_state)
         ST_IDLE: if (start)  w_state_nx = ST_BUSY;
         ST_BUSY: if (w_last) w_state_nx = ST_DONE;
         ST_DONE:             w_state_nx = ST_IDLE;
         default:             w_state_nx = ST_IDLE;
      endcase
      if (flush) w_state_nx = ST_IDLE;
   end

   // ---------------- operand conditioning at accept ----------------
   // MUL keeps unsigned magnitudes: its low half is sign-agnostic.
   assign w_sgn_a = (funct3 == F3_MULH) || (funct3 == F3_MULHSU) ||
                    (funct3 == F3_DIV)  || (funct3 == F3_REM);
   assign w_sgn_b = (funct3 == F3_MULH) || (funct3 == F3_DIV) || (funct3 == F3_REM);
   assign w_neg_a = w_sgn_a & a[XLEN-1];
   assign w_neg_b = w_sgn_b & b[XLEN-1];
   assign w_abs_a = w_neg_a ? (~a + 1'b1) : a;
   assign w_abs_b = w_neg_b ? (~b + 1'b1) : b;

   // ---------------- one iteration step ----------------
   assign w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_ma} : {(XLEN+1){1'b0}});
   assign w_div_sh  = {r_hi, r_lo[XLEN-1]};
   assign w_div_df  = w_div_sh - {1'b0, r_mb};

   always_comb begin
      w_hi_nx = w_mul_sum[XLEN:1];
      w_lo_nx = {w_mul_sum[0], r_lo[XLEN-1:1]};
      if (r_f3[2]) begin
         // restoring divide: keep the difference only if it did not borrow
         w_hi_nx = w_div_df[XLEN] ? w_div_sh[XLEN-1:0] : w_div_df[XLEN-1:0];
         w_lo_nx = {r_lo[XLEN-2:0], ~w_div_df[XLEN]};
      end
   end

   // ---------------- sign fix-up and corner cases ----------------
   assign w_prod   = {w_hi_nx, w_lo_nx};
   assign w_prod_s = r_neg_q ? (~w_prod + 1'b1) : w_prod;
   assign w_q_s    = r_neg_q ? (~w_lo_nx + 1'b1) : w_lo_nx;
   assign w_r_s    = r_neg_r ? (~w_hi_nx + 1'b1) : w_hi_nx;

   always_comb begin
      w_final = w_prod_s[2*XLEN-1:XLEN];
      case (r_f3)
         F3_MUL:                  w_final = w_prod_s[XLEN-1:0];
         F3_MULH, F3_MULHSU,
         F3_MULHU:                w_final = w_prod_s[2*XLEN-1:XLEN];
         F3_DIV, F3_DIVU: begin
            if (r_div0)           w_final = {XLEN{1'b1}};
            else if (r_ovf)       w_final = r_a;
            else                  w_final = w_q_s;
         end
         default: begin
            if (r_div0)           w_final = r_a;
            else if (r_ovf)       w_final = {XLEN{1'b0}};
            else                  w_final = w_r_s;
         end
      endcase
   end

   // ---------------- datapath registers ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt    <= '0;
         r_f3     <= '0;
         r_a      <= '0;
         r_ma     <= '0;
         r_mb     <= '0;
         r_hi     <= '0;
         r_lo     <= '0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_div0   <= 1'b0;
         r_ovf    <= 1'b0;
         r_result <= '0;
      end else if (!flush) begin
         if (r_state == ST_IDLE && start) begin
            r_cnt   <= '0;
            r_f3    <= funct3;
            r_a     <= a;
            r_ma    <= w_abs_a;
            r_mb    <= w_abs_b;
            r_hi    <= '0;
            r_lo    <= funct3[2] ? w_abs_a : w_abs_b;
            r_neg_q <= w_neg_a ^ w_neg_b;
            r_neg_r <= w_neg_a;
            r_div0  <= (b == '0);
            r_ovf   <= ((funct3 == F3_DIV) || (funct3 == F3_REM)) &&
                       (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == {XLEN{1'b1}});
         end else if (r_state == ST_BUSY) begin
            r_hi  <= w_hi_nx;
            r_lo  <= w_lo_nx;
            r_cnt <= r_cnt + CW'(1);
            if (w_last) r_result <= w_final;
         end
      end
   end

   assign busy   = (r_state == ST_BUSY);
   assign done   = (r_state == ST_DONE);
   assign result = r_result;

endmodule : mdu_iter
`default_nettype wire

// File: rtl/alu_exec_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : alu_exec_unit                                                   |
// | Purpose  : Execute stage: ALU control decode, RV32I ALU and (optionally)   |
// |            the iterative RV32M unit. ALU ops are combinational; MDU ops    |
// |            hold the pipeline with stall until their DONE cycle.            |
// | Ports    : clk, rst          clock, synchronous active-high reset         |
// |            in_valid          valid instruction in EX                      |
// |            alu_op,funct3/7   decode inputs                                |
// |            op_a, op_b        operands                                     |
// |            flush             abort in-flight MDU op                       |
// |            result,zero       execute result and result==0                 |
// |            result_valid      result valid this cycle                      |
// |            stall             hold upstream stages                         |
// |            alu_cntrl,illegal decoded control code, unsupported encoding   |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module alu_exec_unit
   import alu_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int MDU_EN = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   input  logic [1:0]      alu_op,
   input  logic [2:0]      funct3,
   input  logic [6:0]      funct7,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   input  logic            flush,
   output logic [XLEN-1:0] result,
   output logic            result_valid,
   output logic            zero,
   output logic            stall,
   output logic [3:0]      alu_cntrl,
   output logic            illegal
);

   localparam int SHW = $clog2(XLEN);

   logic [3:0]      w_ctrl;
   logic            w_dec_ill;
   logic [SHW-1:0]  w_shamt;
   logic [XLEN-1:0] w_alu;
   logic            w_mdu_req;
   logic            w_mdu_busy;
   logic            w_mdu_done;
   logic [XLEN-1:0] w_mdu_result;

   // ---------------- control decode ----------------
   // Illegal encodings fall back to ADD so downstream never sees an unknown code.
   always_comb begin
      w_ctrl    = CTRL_ADD;
      w_dec_ill = 1'b0;
      case (alu_op_e'(alu_op))
         ALUOP_ADD:    w_ctrl = CTRL_ADD;
         ALUOP_BRANCH: w_ctrl = CTRL_SUB;
         ALUOP_RTYPE: begin
            if (funct7 == F7_BASE)                        w_ctrl = base_ctrl(funct3);
            else if (funct7 == F7_ALT && funct3 == 3'b000) w_ctrl = CTRL_SUB;
            else if (funct7 == F7_ALT && funct3 == 3'b101) w_ctrl = CTRL_SRA;
            else if (funct7 == F7_MULDIV && MDU_EN != 0)  w_ctrl = CTRL_MDU;
            else                                          w_dec_ill = 1'b1;
         end
         default: begin
            // I-type: funct7 is immediate except for the shift-immediates
            case (funct3)
               3'b001: begin
                  if (funct7 == F7_BASE) w_ctrl = CTRL_SLL;
                  else                   w_dec_ill = 1'b1;
               end
               3'b101: begin
                  if (funct7 == F7_BASE)     w_ctrl = CTRL_SRL;
                  else if (funct7 == F7_ALT) w_ctrl = CTRL_SRA;
                  else                       w_dec_ill = 1'b1;
               end
               default: w_ctrl = base_ctrl(funct3);
            endcase
         end
      endcase
   end

   // ---------------- ALU ----------------
   assign w_shamt = op_b[SHW-1:0];

   always_comb begin
      w_alu = '0;
      case (w_ctrl)
         CTRL_AND:  w_alu = op_a & op_b;
         CTRL_OR:   w_alu = op_a | op_b;
         CTRL_ADD:  w_alu = op_a + op_b;
         CTRL_XOR:  w_alu = op_a ^ op_b;
         CTRL_SLL:  w_alu = op_a << w_shamt;
         CTRL_SRL:  w_alu = op_a >> w_shamt;
         CTRL_SUB:  w_alu = op_a - op_b;
         CTRL_SRA:  w_alu = $unsigned($signed(op_a) >>> w_shamt);
         CTRL_SLT:  w_alu = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
         CTRL_SLTU: w_alu = {{(XLEN-1){1'b0}}, (op_a < op_b)};
         default:   w_alu = '0;
      endcase
   end

   // CTRL_MDU is only decoded when the MDU exists and the encoding is legal
   assign w_mdu_req = in_valid & (w_ctrl == CTRL_MDU);

   // ---------------- multiply / divide ----------------
   generate
      if (MDU_EN != 0) begin : g_mdu
         mdu_iter #(
            .XLEN (XLEN)
         ) u_mdu (
            .clk    (clk),
            .rst    (rst),
            .flush  (flush),
            .start  (w_mdu_req & ~flush),
            .funct3 (funct3),
            .a      (op_a),
            .b      (op_b),
            .busy   (w_mdu_busy),
            .done   (w_mdu_done),
            .result (w_mdu_result)
         );
      end else begin : g_no_mdu
         assign w_mdu_busy   = 1'b0;
         assign w_mdu_done   = 1'b0;
         assign w_mdu_result = '0;
      end
   endgenerate

   // ---------------- output steering ----------------
   always_comb begin
      stall        = 1'b0;
      result_valid = 1'b0;
      illegal      = 1'b0;
      result       = w_mdu_done ? w_mdu_result : w_alu;
      if (!rst) begin
         illegal = in_valid & w_dec_ill;
         if (w_mdu_busy) begin
            stall = 1'b1;
         end else if (w_mdu_done) begin
            // DONE ignores the still-presented MDU instruction
            result_valid = ~flush;
         end else begin
            stall        = w_mdu_req & ~flush;
            result_valid = in_valid & ~w_dec_ill & ~w_mdu_req;
         end
      end
   end

   assign zero      = (result == '0);
   assign alu_cntrl = w_ctrl;

endmodule : alu_exec_unit
`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_alu_exec_unit                                                |
// | Purpose  : Self-checking bench for alu_exec_unit: directed vectors with    |
// |            literal expectations plus an every-cycle comparison against a   |
// |            behavioural model (MDU_EN=1 and MDU_EN=0 instances).            |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_alu_exec_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic [1:0]  alu_op = 2'b00;
   logic [2:0]  funct3 = 3'b000;
   logic [6:0]  funct7 = 7'b0000000;
   logic [31:0] op_a = 32'd0;
   logic [31:0] op_b = 32'd0;
   logic        flush = 1'b0;

   logic [31:0] res1, res0;
   logic        rv1, rv0, zr1, zr0, st1, st0, il1, il0;
   logic [3:0]  ct1, ct0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   alu_exec_unit #(.XLEN(32), .MDU_EN(1)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .alu_op(alu_op), .funct3(funct3),
      .funct7(funct7), .op_a(op_a), .op_b(op_b), .flush(flush), .result(res1),
      .result_valid(rv1), .zero(zr1), .stall(st1), .alu_cntrl(ct1), .illegal(il1));

   alu_exec_unit #(.XLEN(32), .MDU_EN(0)) dut0 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .alu_op(alu_op), .funct3(funct3),
      .funct7(funct7), .op_a(op_a), .op_b(op_b), .flush(flush), .result(res0),
      .result_valid(rv0), .zero(zr0), .stall(st0), .alu_cntrl(ct0), .illegal(il0));

   // ---------------- comparison helper ----------------
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // returns {illegal, control}
   function automatic logic [4:0] m_decode(input logic [1:0] aop, input logic [2:0] f3,
                                           input logic [6:0] f7, input bit mden);
      logic [3:0] base [8];
      base[0] = 4'd2; base[1] = 4'd4; base[2] = 4'd8; base[3] = 4'd9;
      base[4] = 4'd3; base[5] = 4'd5; base[6] = 4'd1; base[7] = 4'd0;
      if (aop == 2'b00) return {1'b0, 4'd2};
      if (aop == 2'b01) return {1'b0, 4'd6};
      if (aop == 2'b10) begin
         if (f7 == 7'h00) return {1'b0, base[f3]};
         if (f7 == 7'h20 && f3 == 3'd0) return {1'b0, 4'd6};
         if (f7 == 7'h20 && f3 == 3'd5) return {1'b0, 4'd7};
         if (f7 == 7'h01 && mden) return {1'b0, 4'd15};
         return {1'b1, 4'd2};
      end
      if (f3 == 3'd1) return (f7 == 7'h00) ? {1'b0, 4'd4} : {1'b1, 4'd2};
      if (f3 == 3'd5) begin
         if (f7 == 7'h00) return {1'b0, 4'd5};
         if (f7 == 7'h20) return {1'b0, 4'd7};
         return {1'b1, 4'd2};
      end
      return {1'b0, base[f3]};
   endfunction

   function automatic logic [31:0] m_alu(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
      int sh;
      sh = int'(b % 32);
      case (c)
         4'd0: return a & b;
         4'd1: return a | b;
         4'd2: return a + b;
         4'd3: return a ^ b;
         4'd4: return a << sh;
         4'd5: return a >> sh;
         4'd6: return a - b;
         4'd7: return $unsigned($signed(a) >>> sh);
         4'd8: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'd9: return (a < b) ? 32'd1 : 32'd0;
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic [31:0] m_mdu(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      longint     sa, sb, sp;
      logic [63:0] up;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (f3)
         3'd0: begin up = {32'd0, a} * {32'd0, b}; return up[31:0]; end
         3'd1: begin sp = sa * sb; return sp[63:32]; end
         3'd2: begin sp = sa * longint'({32'd0, b}); return sp[63:32]; end
         3'd3: begin up = {32'd0, a} * {32'd0, b}; return up[63:32]; end
         3'd4: begin
            if (b == 32'd0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
            sp = sa / sb; return sp[31:0];
         end
         3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
         3'd6: begin
            if (b == 32'd0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
            sp = sa % sb; return sp[31:0];
         end
         default: return (b == 32'd0) ? a : a % b;
      endcase
   endfunction

   // phase per instance: 0 idle, 1..32 busy step, 33 done
   int          ph [2] = '{0, 0};
   logic [2:0]  mf3 [2];
   logic [31:0] ma [2], mb [2];

   always @(posedge clk) begin
      for (int u = 0; u < 2; u++) begin
         logic [4:0] d;
         d = m_decode(alu_op, funct3, funct7, u == 1);
         if (rst || flush) ph[u] = 0;
         else if (ph[u] == 0) begin
            if (in_valid && !d[4] && d[3:0] == 4'd15) begin
               ph[u] = 1; mf3[u] = funct3; ma[u] = op_a; mb[u] = op_b;
            end
         end else if (ph[u] == 33) ph[u] = 0;
         else ph[u] = ph[u] + 1;
      end
   end

   task automatic check_unit(input int u, input logic st, input logic rv, input logic il,
                             input logic zr, input logic [3:0] ct, input logic [31:0] res);
      logic [4:0]  d;
      logic        e_st, e_rv, e_il, mdu;
      logic [31:0] e_res;
      d     = m_decode(alu_op, funct3, funct7, u == 1);
      e_il  = !rst && in_valid && d[4];
      mdu   = in_valid && !d[4] && d[3:0] == 4'd15;
      e_res = m_alu(d[3:0], op_a, op_b);
      if (rst) begin
         e_st = 1'b0; e_rv = 1'b0;
      end else if (ph[u] >= 1 && ph[u] <= 32) begin
         e_st = 1'b1; e_rv = 1'b0;
      end else if (ph[u] == 33) begin
         e_st = 1'b0; e_rv = !flush; e_res = m_mdu(mf3[u], ma[u], mb[u]);
      end else begin
         e_st = mdu && !flush; e_rv = in_valid && !d[4] && !mdu;
      end
      chk($sformatf("u%0d stall", u), {31'd0, st}, {31'd0, e_st});
      chk($sformatf("u%0d result_valid", u), {31'd0, rv}, {31'd0, e_rv});
      chk($sformatf("u%0d illegal", u), {31'd0, il}, {31'd0, e_il});
      chk($sformatf("u%0d alu_cntrl", u), {28'd0, ct}, {28'd0, d[3:0]});
      if (e_rv) begin
         chk($sformatf("u%0d result", u), res, e_res);
         chk($sformatf("u%0d zero", u), {31'd0, zr}, {31'd0, (e_res == 32'd0)});
      end
   endtask

   always @(negedge clk) begin
      check_unit(1, st1, rv1, il1, zr1, ct1, res1);
      check_unit(0, st0, rv0, il0, zr0, ct0, res0);
   end

   // ---------------- directed stimulus ----------------
   int          l_nst, l_nrv;
   logic [31:0] l_res;
   logic        l_ill, l_zero;
   logic [3:0]  l_ctl;

   task automatic issue(input logic [1:0] aop, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] a, input logic [31:0] b);
      @(posedge clk); #1;
      alu_op = aop; funct3 = f3; funct7 = f7; op_a = a; op_b = b; in_valid = 1'b1;
      l_nst = 0; l_nrv = 0;
      @(negedge clk);
      while (st1 && l_nst < 100) begin
         l_nst++;
         if (rv1) l_nrv++;
         @(negedge clk);
      end
      if (l_nst >= 100) chk("stall timeout", 32'd1, 32'd0);
      if (rv1) l_nrv++;
      l_res = res1; l_ill = il1; l_zero = zr1; l_ctl = ct1;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic alu_case(input string nm, input logic [1:0] aop, input logic [2:0] f3,
                           input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp);
      issue(aop, f3, f7, a, b);
      chk({nm, " result"}, l_res, exp);
      chk({nm, " stall cycles"}, l_nst, 32'd0);
      chk({nm, " valid pulses"}, l_nrv, 32'd1);
   endtask

   task automatic mdu_case(input string nm, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp);
      issue(2'b10, f3, 7'h01, a, b);
      chk({nm, " result"}, l_res, exp);
      chk({nm, " stall cycles"}, l_nst, 32'd33);
      chk({nm, " valid pulses"}, l_nrv, 32'd1);
   endtask

   initial begin
      int pulses;
      // reset state
      @(negedge clk);
      chk("reset stall", {31'd0, st1}, 32'd0);
      chk("reset result_valid", {31'd0, rv1}, 32'd0);
      chk("reset illegal", {31'd0, il1}, 32'd0);
      @(posedge clk); #1 rst = 1'b0;

      // single-cycle ALU ops
      alu_case("SUB",  2'b10, 3'd0, 7'h20, 32'd5, 32'd7, 32'hFFFF_FFFE);
      alu_case("SRA",  2'b10, 3'd5, 7'h20, 32'h8000_0000, 32'd4, 32'hF800_0000);
      alu_case("SLTU", 2'b10, 3'd3, 7'h00, 32'd1, 32'hFFFF_FFFF, 32'd1);
      alu_case("SLT",  2'b10, 3'd2, 7'h00, 32'hFFFF_FFFF, 32'd1, 32'd1);
      alu_case("ADD",  2'b00, 3'd7, 7'h7F, 32'd3, 32'd4, 32'd7);
      alu_case("BEQ",  2'b01, 3'd0, 7'h00, 32'd9, 32'd9, 32'd0);
      chk("BEQ zero", {31'd0, l_zero}, 32'd1);
      alu_case("ADDI", 2'b11, 3'd0, 7'h20, 32'd10, 32'd5, 32'd15);
      chk("ADDI ctrl", {28'd0, l_ctl}, 32'd2);
      alu_case("SLLI", 2'b11, 3'd1, 7'h00, 32'd1, 32'd36, 32'd16);
      alu_case("SRAI", 2'b11, 3'd5, 7'h20, 32'hF000_0000, 32'd8, 32'hFFF0_0000);
      alu_case("OR",   2'b10, 3'd6, 7'h00, 32'h0F0F_0000, 32'h0000_F0F0, 32'h0F0F_F0F0);

      // illegal R-type
      issue(2'b10, 3'd0, 7'h02, 32'd1, 32'd2);
      chk("illegal flag", {31'd0, l_ill}, 32'd1);
      chk("illegal valid", l_nrv, 32'd0);
      chk("illegal ctrl", {28'd0, l_ctl}, 32'd2);

      // multiply / divide
      mdu_case("MUL",    3'd0, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE);
      mdu_case("MULH",   3'd1, 32'hFFFF_FFFD, 32'd4, 32'hFFFF_FFFF);
      mdu_case("MULHU",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
      mdu_case("MULHSU", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      mdu_case("DIV0",   3'd4, 32'd7, 32'd0, 32'hFFFF_FFFF);
      mdu_case("REM0",   3'd6, 32'd7, 32'd0, 32'd7);
      mdu_case("DIVOVF", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
      mdu_case("REMOVF", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
      mdu_case("DIVNEG", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
      mdu_case("REMNEG", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
      mdu_case("DIVU",   3'd5, 32'd100, 32'd7, 32'd14);
      mdu_case("REMU",   3'd7, 32'd100, 32'd7, 32'd2);

      // flush in BUSY cycle 10
      @(posedge clk); #1;
      alu_op = 2'b10; funct3 = 3'd0; funct7 = 7'h01; op_a = 32'd3; op_b = 32'd5; in_valid = 1'b1;
      repeat (10) @(posedge clk);
      #1 flush = 1'b1;
      @(negedge clk);
      chk("flush cycle stall", {31'd0, st1}, 32'd1);
      @(posedge clk); #1;
      flush = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      chk("post-flush stall", {31'd0, st1}, 32'd0);
      chk("post-flush valid", {31'd0, rv1}, 32'd0);
      alu_case("ADD after flush", 2'b00, 3'd0, 7'h00, 32'd2, 32'd3, 32'd5);

      // reset mid-BUSY; MDU-less instance flags the MUL
      @(posedge clk); #1;
      alu_op = 2'b10; funct3 = 3'd0; funct7 = 7'h01; op_a = 32'd6; op_b = 32'd7; in_valid = 1'b1;
      @(negedge clk);
      chk("no-MDU illegal", {31'd0, il0}, 32'd1);
      chk("no-MDU valid", {31'd0, rv0}, 32'd0);
      chk("no-MDU stall", {31'd0, st0}, 32'd0);
      repeat (5) @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      chk("rst-busy stall", {31'd0, st1}, 32'd0);
      chk("rst-busy valid", {31'd0, rv1}, 32'd0);
      chk("rst-busy illegal", {31'd0, il1}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0; in_valid = 1'b0;
      pulses = 0;
      repeat (40) begin
         @(negedge clk);
         if (rv1) pulses++;
      end
      chk("rst-busy no DONE", pulses, 32'd0);

      repeat (2) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_alu_exec_unit
`default_nettype wire
